// File: rtl/mips_run_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mips_run_ctrl
//
// Purpose:
//   Supervises one "run" of an attached MIPS core.  A start request puts the
//   core into reset for RESET_CYCLES cycles.  The core is then released and
//   runs until one of three things happens:
//     - it fetches the halt instruction (HALT_INSTR, a syscall by default),
//     - it uses up the cycle budget given with the start request, or
//     - its PC stays unchanged for STALL_LIMIT consecutive RUN cycles.
//   After termination the core is held in reset again.  The cause, the PC at
//   termination and the number of RUN cycles stay available until the next
//   start request.
//
// Parameters:
//   RESET_CYCLES  cycles cpu_rst_n is held low before a run (1..255)
//   HALT_INSTR    instruction word that ends a run
//   STALL_LIMIT   consecutive equal-PC RUN cycles that end a run (2..255)
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous active-high reset, overrides start
//   start        in   1  one-cycle request to begin a run (IDLE/DONE only)
//   cycle_limit  in  32  maximum RUN cycles, 0 = unlimited, taken at start
//   pc           in  32  core program counter
//   instr        in  32  instruction the core is currently fetching
//   cpu_rst_n    out  1  active-low reset to the core, high only in RUN
//   running      out  1  high in RUN
//   done         out  1  high in DONE
//   halt_cause   out  2  00 none, 01 halt instr, 10 cycle limit, 11 PC stall
//   cycle_cnt    out 32  RUN cycles in the current or last run, saturating
//   final_pc     out 32  pc sampled in the terminating cycle
//
// Every output is either a flop or a decode of the state register, so there
// is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module mips_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] HALT_INSTR   = 32'h0000000C,
  parameter int unsigned STALL_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cycle_limit,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        cpu_rst_n,
  output logic        running,
  output logic        done,
  output logic [1:0]  halt_cause,
  output logic [31:0] cycle_cnt,
  output logic [31:0] final_pc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_HALT  = 2'b01;
  localparam logic [1:0] CAUSE_LIMIT = 2'b10;
  localparam logic [1:0] CAUSE_STALL = 2'b11;

  // Reset counter load value.
  localparam logic [7:0] RESET_LOAD = 8'(RESET_CYCLES);

  // The stall counter holds the number of equal-PC comparisons seen so far in
  // the current stretch.  When it already holds STALL_LIMIT-2 and the PC is
  // unchanged again, it would reach STALL_LIMIT-1: that is the STALL_LIMIT-th
  // cycle with the same PC, so the run ends in this cycle.
  localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 2);

  state_t      state_q,       state_d;
  logic [31:0] limit_q,       limit_d;
  logic [31:0] cycle_cnt_q,   cycle_cnt_d;
  logic [1:0]  halt_cause_q,  halt_cause_d;
  logic [31:0] final_pc_q,    final_pc_d;
  logic [7:0]  rst_cnt_q,     rst_cnt_d;
  logic [7:0]  stall_cnt_q,   stall_cnt_d;
  logic [31:0] prev_pc_q,     prev_pc_d;

  logic [31:0] cnt_inc;
  logic        first_cycle;
  logic        pc_same;
  logic        halt_hit;
  logic        limit_hit;
  logic        stall_hit;

  // Termination conditions, evaluated on the pc/instr values the flops sample
  // at the end of the current RUN cycle.
  // cycle_cnt is cleared on every accepted start and only counts in RUN, so a
  // zero count in RUN marks the first RUN cycle.  There is no previous PC to
  // compare against in that cycle.
  always_comb begin
    cnt_inc     = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    first_cycle = (cycle_cnt_q == 32'd0);
    pc_same     = !first_cycle && (pc == prev_pc_q);
    halt_hit    = (instr == HALT_INSTR);
    // The count is widened by one bit so that the +1 cannot wrap.
    limit_hit   = (limit_q != 32'd0) &&
                  (({1'b0, cycle_cnt_q} + 33'd1) == {1'b0, limit_q});
    stall_hit   = pc_same && (stall_cnt_q == STALL_LAST);
  end

  // Next-state and datapath logic.  Every register holds its value by
  // default.  Each state then overrides only what it changes.
  always_comb begin
    state_d      = state_q;
    limit_d      = limit_q;
    cycle_cnt_d  = cycle_cnt_q;
    halt_cause_d = halt_cause_q;
    final_pc_d   = final_pc_q;
    rst_cnt_d    = rst_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    prev_pc_d    = prev_pc_q;

    unique case (state_q)
      // IDLE and DONE both accept a start.  Accepting it clears the results
      // of the previous run, so they do not linger while the core is in
      // reset.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RESET;
          limit_d      = cycle_limit;
          cycle_cnt_d  = 32'd0;
          halt_cause_d = CAUSE_NONE;
          final_pc_d   = 32'd0;
          rst_cnt_d    = RESET_LOAD;
          stall_cnt_d  = 8'd0;
        end
      end

      // The counter is loaded with RESET_CYCLES and leaves on the cycle it
      // reads 1, which gives exactly RESET_CYCLES cycles in this state.
      ST_RESET: begin
        rst_cnt_d = rst_cnt_q - 8'd1;
        if (rst_cnt_q <= 8'd1) begin
          state_d     = ST_RUN;
          rst_cnt_d   = 8'd0;
          stall_cnt_d = 8'd0;
        end
      end

      // The terminating cycle is still counted and its PC is captured.
      // The causes are checked in priority order: halt, then limit, then
      // stall.
      ST_RUN: begin
        cycle_cnt_d = cnt_inc;
        prev_pc_d   = pc;
        stall_cnt_d = pc_same ? stall_cnt_q + 8'd1 : 8'd0;
        if (halt_hit || limit_hit || stall_hit) begin
          state_d    = ST_DONE;
          final_pc_d = pc;
          if (halt_hit) begin
            halt_cause_d = CAUSE_HALT;
          end else if (limit_hit) begin
            halt_cause_d = CAUSE_LIMIT;
          end else begin
            halt_cause_d = CAUSE_STALL;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.  rst is synchronous and overrides
  // everything, including a start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      limit_q      <= 32'd0;
      cycle_cnt_q  <= 32'd0;
      halt_cause_q <= CAUSE_NONE;
      final_pc_q   <= 32'd0;
      rst_cnt_q    <= 8'd0;
      stall_cnt_q  <= 8'd0;
      prev_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      limit_q      <= limit_d;
      cycle_cnt_q  <= cycle_cnt_d;
      halt_cause_q <= halt_cause_d;
      final_pc_q   <= final_pc_d;
      rst_cnt_q    <= rst_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      prev_pc_q    <= prev_pc_d;
    end
  end

  // The status outputs decode the state register only.  The result outputs
  // come straight from their flops.
  assign cpu_rst_n  = (state_q == ST_RUN);
  assign running    = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign halt_cause = halt_cause_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign final_pc   = final_pc_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
`timescale 1ns/1ps
// Testbench for mips_run_ctrl.  It applies a table of directed runs, a few
// hand-written multi-cycle sequences, and randomized runs that are checked
// against a run-level reference model.
module tb_mips_run_ctrl;

  localparam int          RESET_CYCLES = 2;
  localparam int          STALL_LIMIT  = 4;
  localparam logic [31:0] HALT         = 32'h0000000C;
  localparam logic [31:0] NOP_INSTR    = 32'h00221820;
  localparam int          MAXC         = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] cycle_limit;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        cpu_rst_n;
  logic        running;
  logic        done;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt;
  logic [31:0] final_pc;

  int checks = 0;
  int errors = 0;

  // Per-RUN-cycle stimulus.  Index k is RUN cycle k, counting from 1.
  logic [31:0] pc_arr    [1:MAXC];
  logic [31:0] instr_arr [1:MAXC];

  typedef struct {
    logic [31:0] limit;
    int          halt_cyc;
    int          stall_from;
    logic [31:0] stall_pc;
    int          start_mid;
    logic [31:0] exp_cause;
    logic [31:0] exp_cnt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [10];

  mips_run_ctrl #(
    .RESET_CYCLES(RESET_CYCLES),
    .HALT_INSTR  (HALT),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cycle_limit(cycle_limit),
    .pc         (pc),
    .instr      (instr),
    .cpu_rst_n  (cpu_rst_n),
    .running    (running),
    .done       (done),
    .halt_cause (halt_cause),
    .cycle_cnt  (cycle_cnt),
    .final_pc   (final_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Builds one run at the level of whole runs.  Each cycle extends the
  // current equal-PC stretch or starts a new one.  The first cause that
  // applies in a cycle, in priority order, ends the run.
  task automatic refModel(input logic [31:0] limit, output logic [31:0] cause,
                          output logic [31:0] cnt, output logic [31:0] fpc);
    int stretch;
    stretch = 0;
    cause = 0;
    cnt = 0;
    fpc = 0;
    for (int k = 1; k <= MAXC; k++) begin
      stretch = (k > 1 && pc_arr[k] == pc_arr[k-1]) ? stretch + 1 : 1;
      if (instr_arr[k] == HALT)                 cause = 1;
      else if (limit != 0 && k == int'(limit))  cause = 2;
      else if (stretch >= STALL_LIMIT)          cause = 3;
      if (cause != 0) begin
        cnt = k;
        fpc = pc_arr[k];
        break;
      end
    end
  endtask

  // Performs one full run from IDLE or DONE.  If start_mid is nonzero, it
  // also pulses start with a conflicting limit in that RUN cycle.
  task automatic applyStimulus(input logic [31:0] limit, input int start_mid,
                               input logic [31:0] exp_cause, input logic [31:0] exp_cnt,
                               input logic [31:0] exp_pc, input string tag);
    int rc;
    int k;
    logic bad_rst_n;
    start = 1'b1;
    cycle_limit = limit;
    tick();
    start = 1'b0;
    cycle_limit = $urandom;
    checkOutput({tag, " cause_clr"}, 32'(halt_cause), 32'd0);
    checkOutput({tag, " cnt_clr"}, cycle_cnt, 32'd0);
    checkOutput({tag, " done_clr"}, 32'(done), 32'd0);
    rc = 0;
    bad_rst_n = 1'b0;
    while (!running && rc < 300) begin
      if (cpu_rst_n !== 1'b0) bad_rst_n = 1'b1;
      rc++;
      tick();
    end
    checkOutput({tag, " reset_len"}, 32'(rc), 32'(RESET_CYCLES));
    k = 1;
    while (running === 1'b1 && k <= MAXC) begin
      if (cpu_rst_n !== 1'b1) bad_rst_n = 1'b1;
      pc = pc_arr[k];
      instr = instr_arr[k];
      if (k == start_mid) begin
        start = 1'b1;
        cycle_limit = 32'd1;
      end
      tick();
      start = 1'b0;
      k++;
    end
    instr = NOP_INSTR;
    checkOutput({tag, " cpu_rst_n_seq"}, 32'(bad_rst_n), 32'd0);
    checkOutput({tag, " run_len"}, 32'(k - 1), exp_cnt);
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " running"}, 32'(running), 32'd0);
    checkOutput({tag, " cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    checkOutput({tag, " cause"}, 32'(halt_cause), exp_cause);
    checkOutput({tag, " cycle_cnt"}, cycle_cnt, exp_cnt);
    checkOutput({tag, " final_pc"}, final_pc, exp_pc);
    pc = $urandom;
    tick();
    tick();
    checkOutput({tag, " hold_done"}, 32'(done), 32'd1);
    checkOutput({tag, " hold_cnt"}, cycle_cnt, exp_cnt);
    checkOutput({tag, " hold_pc"}, final_pc, exp_pc);
    if (running === 1'b1 || done !== 1'b1) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
  endtask

  task automatic fillDirected(input vec_t v);
    for (int k = 1; k <= MAXC; k++) begin
      pc_arr[k] = (v.stall_from != 0 && k >= v.stall_from) ? v.stall_pc
                                                           : 32'h100 + 32'(4 * k);
      instr_arr[k] = (k == v.halt_cyc) ? HALT : NOP_INSTR;
    end
  endtask

  initial begin
    logic [31:0] ec, en, ep, lim;

    //        limit halt stall stall_pc    mid cause cnt  final_pc
    vecs[0] = '{32'd17, 0, 0, 32'h0,  0, 2, 17, 32'h144};
    vecs[1] = '{32'd0,  5, 0, 32'h0,  3, 1,  5, 32'h114};
    vecs[2] = '{32'd0,  0, 3, 32'h20, 0, 3,  6, 32'h20};
    vecs[3] = '{32'd6,  6, 0, 32'h0,  0, 1,  6, 32'h118};
    vecs[4] = '{32'd1,  0, 0, 32'h0,  0, 2,  1, 32'h104};
    vecs[5] = '{32'd0,  1, 0, 32'h0,  0, 1,  1, 32'h104};
    vecs[6] = '{32'd0,  0, 1, 32'h20, 0, 3,  4, 32'h20};
    vecs[7] = '{32'd5,  0, 2, 32'h20, 0, 2,  5, 32'h20};
    vecs[8] = '{32'd0,  5, 2, 32'h20, 0, 1,  5, 32'h20};
    vecs[9] = '{32'd0,  0, 2, 32'h20, 2, 3,  5, 32'h20};

    rst = 1'b1;
    start = 1'b0;
    cycle_limit = 32'd0;
    pc = 32'd0;
    instr = NOP_INSTR;
    repeat (3) tick();
    checkOutput("por cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("por running", 32'(running), 32'd0);
    checkOutput("por done", 32'(done), 32'd0);
    checkOutput("por cause", 32'(halt_cause), 32'd0);
    checkOutput("por cnt", cycle_cnt, 32'd0);
    checkOutput("por final_pc", final_pc, 32'd0);
    rst = 1'b0;
    tick();

    // A reset in the same cycle as start wins, so no run may begin.
    rst = 1'b1;
    start = 1'b1;
    cycle_limit = 32'd3;
    tick();
    rst = 1'b0;
    start = 1'b0;
    repeat (RESET_CYCLES + 6) tick();
    checkOutput("rst_prio running", 32'(running), 32'd0);
    checkOutput("rst_prio done", 32'(done), 32'd0);

    for (int i = 0; i < 10; i++) begin
      fillDirected(vecs[i]);
      applyStimulus(vecs[i].limit, vecs[i].start_mid, vecs[i].exp_cause,
                    vecs[i].exp_cnt, vecs[i].exp_pc, $sformatf("vec%0d", i));
    end

    // Reset asserted in RUN cycle 8 returns to IDLE with cleared results.
    // A subsequent run must then start counting from zero.
    fillDirected(vecs[0]);
    start = 1'b1;
    cycle_limit = 32'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && !running; i++) tick();
    for (int k = 1; k <= 7; k++) begin
      pc = pc_arr[k];
      tick();
    end
    checkOutput("midrst cnt7", cycle_cnt, 32'd7);
    checkOutput("midrst running", 32'(running), 32'd1);
    pc = pc_arr[8];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("midrst running0", 32'(running), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    checkOutput("midrst cause", 32'(halt_cause), 32'd0);
    checkOutput("midrst cnt", cycle_cnt, 32'd0);
    checkOutput("midrst final_pc", final_pc, 32'd0);
    applyStimulus(vecs[0].limit, 0, vecs[0].exp_cause, vecs[0].exp_cnt,
                  vecs[0].exp_pc, "after_rst");

    // Randomized runs checked against the run-level model.
    for (int r = 0; r < 30; r++) begin
      logic [31:0] cur;
      cur = {$urandom_range(0, 255), 2'b00};
      for (int k = 1; k <= MAXC; k++) begin
        if (k > 1 && $urandom_range(0, 9) < 4) cur = cur;
        else if ($urandom_range(0, 3) == 0) cur = {$urandom_range(0, 1023), 2'b00};
        else cur = cur + 32'd4;
        pc_arr[k] = cur;
        instr_arr[k] = ($urandom_range(0, 24) == 0) ? HALT : (NOP_INSTR | 32'($urandom_range(1, 255)) << 8);
      end
      instr_arr[MAXC - 4] = HALT;
      lim = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      refModel(lim, ec, en, ep);
      applyStimulus(lim, 0, ec, en, ep, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_CYCLES, default 2, meaning the number of cycles cpu_rst_n is held low before a run (legal range 1..255).
REQ-002 The block SHALL have parameter HALT_INSTR, default 32'h0000000C (syscall), meaning the instruction word that ends a run.
REQ-003 The block SHALL have parameter STALL_LIMIT, default 4, meaning the number of consecutive unchanged-PC RUN cycles that ends a run (legal range 2..255).
REQ-004 The block SHALL use one clock, clk; reset, rst, is synchronous and active-high.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a run
- cycle_limit  in  32  maximum RUN cycles; 0 means unlimited; sampled on the accepted start
- pc  in  32  CPU program counter
- instr  in  32  CPU instruction currently fetched
- cpu_rst_n  out  1  active-low reset driven to the MIPS core
- running  out  1  high in RUN
- done  out  1  high in DONE
- halt_cause  out  2  00 none, 01 halt instruction, 10 cycle limit, 11 PC stall
- cycle_cnt  out  32  RUN cycles elapsed in the current or last run
- final_pc  out  32  pc value captured at termination

Function
REQ-006 The block SHALL implement an FSM with states IDLE, RESET, RUN and DONE.
REQ-007 In IDLE, cpu_rst_n=0, running=0 and done=0; start=1 SHALL move the FSM to RESET, latch cycle_limit, clear cycle_cnt, halt_cause and final_pc, and load the reset counter with RESET_CYCLES.
REQ-008 RESET SHALL hold cpu_rst_n=0 for exactly RESET_CYCLES cycles, then enter RUN.
REQ-009 In RUN, cpu_rst_n=1 and running=1, and cycle_cnt SHALL increment by 1 every cycle, saturating at 32'hFFFFFFFF.
REQ-010 In RUN, termination SHALL be evaluated every cycle on the registered inputs, with priority halt instruction, then cycle limit, then stall:
- halt instruction: instr==HALT_INSTR gives cause 01
- cycle limit: latched limit nonzero and cycle_cnt+1==limit gives cause 10
- stall: stall counter reaches STALL_LIMIT-1 while pc equals the previous-cycle pc gives cause 11
REQ-011 The stall counter SHALL clear on the first RUN cycle and on any pc change, and SHALL increment while pc is unchanged.
REQ-012 On termination, the next cycle SHALL be DONE, with halt_cause, final_pc (pc in the terminating cycle) and cycle_cnt (including the terminating cycle) registered.
REQ-013 In DONE, done=1, running=0 and cpu_rst_n=0 (core frozen in reset); halt_cause, final_pc and cycle_cnt SHALL hold.
REQ-014 start in DONE SHALL behave as in IDLE (rerun); start in RESET or RUN SHALL be ignored.
REQ-015 With cycle_limit=0 and no halt or stall, RUN SHALL continue indefinitely, with cycle_cnt saturating.
REQ-016 With cycle_limit=1, the run SHALL terminate in its first RUN cycle with cycle_cnt=1.
REQ-017 All outputs SHALL be registered or decoded from state only; there is no combinational path from input to output.

Reset
REQ-018 rst=1 SHALL force IDLE at any state, including mid-RUN, with cpu_rst_n=0, running=0, done=0, halt_cause=00, cycle_cnt=0, final_pc=0, and the internal counters cleared.
REQ-019 rst SHALL take priority over start in the same cycle.

Verification
REQ-020 start with cycle_limit=17 and constant non-halt instr, pc advancing by 4 -> 2 cycles cpu_rst_n=0, 17 cycles running=1, then done=1, halt_cause=10, cycle_cnt=17.
REQ-021 start with limit=0; instr=32'h0000000C in RUN cycle 5 -> done next cycle, halt_cause=01, cycle_cnt=5, final_pc = pc of cycle 5.
REQ-022 pc held at 32'h00000020 from RUN cycle 3 onward with limit=0 -> halt_cause=11 after 4 equal-pc cycles, final_pc=32'h00000020.
REQ-023 halt instr and the cycle limit coincide (limit=6, halt in cycle 6) -> halt_cause=01, cycle_cnt=6.
REQ-024 rst asserted in RUN cycle 8 -> next cycle IDLE with all outputs at reset values; a subsequent start runs normally from cycle_cnt=0.
REQ-025 start pulsed during RUN is ignored; start in DONE restarts with a new cycle_limit, and halt_cause clears to 00 on entry to RESET.
